// File: rtl/banked_image_loader.sv
// rtl/banked_image_loader.sv - Avalon-MM image/weight loader with banked image stream-out
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   chipselect, write, read        Avalon slave strobes
//   address, writedata, readdata   0=DATA 1=CTRL 2=STATUS 3=reserved; readdata registered
//   out_valid, out_ready           image stream handshake
//   out_data, out_last             lane k = image bank k; last marks final bank address
//   wgt_raddr, wgt_rdata           weight random-access read, 1-cycle latency
module banked_image_loader #(
  parameter int PIX_W     = 8,
  parameter int NUM_BANKS = 4,
  parameter int IMG_DEPTH = 196,
  parameter int WGT_DEPTH = 1024,
  parameter int CNT_W     = 16,
  localparam int WORD_W   = NUM_BANKS * PIX_W,
  localparam int WA       = $clog2(WGT_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [1:0]        address,
  input  logic [WORD_W-1:0] writedata,
  output logic [31:0]       readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic [WA-1:0]     wgt_raddr,
  output logic [WORD_W-1:0] wgt_rdata
);

  localparam int IA = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
  localparam int IC = $clog2(IMG_DEPTH + 1);
  localparam int WC = $clog2(WGT_DEPTH + 1);
  localparam logic [IC-1:0]    IMG_END  = IC'(IMG_DEPTH);
  localparam logic [IC-1:0]    IMG_LAST = IC'(IMG_DEPTH - 1);
  localparam logic [WC-1:0]    WGT_LAST = WC'(WGT_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_IMG = 3'd1,
    LOAD_WGT = 3'd2,
    READY    = 3'd3,
    STREAM   = 3'd4
  } state_t;

  state_t            state;
  logic [IC-1:0]     img_cnt;
  logic [WC-1:0]     wgt_cnt;
  logic [IC-1:0]     rd_ptr;
  logic [CNT_W-1:0]  load_cnt;
  logic              overflow;

  logic              data_wr;
  logic              ctrl_wr;
  logic              clear;
  logic              start;
  logic              img_we;
  logic              wgt_we;
  logic              fetch;
  logic [31:0]       status;

  always_comb begin
    data_wr = chipselect & write & (address == 2'd0);
    ctrl_wr = chipselect & write & (address == 2'd1);
    clear   = ctrl_wr & writedata[1];
    start   = ctrl_wr & writedata[0] & ~writedata[1] & (state == READY);
    img_we  = data_wr & ~reset & ((state == IDLE) || (state == LOAD_IMG));
    wgt_we  = data_wr & ~reset & (state == LOAD_WGT);
    // The bank read register doubles as the output register: it only
    // advances when it is empty or being consumed, so stalls hold data.
    fetch   = ~reset & ~clear & (state == STREAM) & (rd_ptr != IMG_END)
              & (~out_valid | out_ready);
    status  = {16'(load_cnt), 12'd0, overflow, state};
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [PIX_W-1:0] mem [IMG_DEPTH];
    logic [PIX_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (img_we) mem[img_cnt[IA-1:0]] <= writedata[k*PIX_W +: PIX_W];
      if (fetch)  rd_q <= mem[rd_ptr[IA-1:0]];
    end

    assign out_data[k*PIX_W +: PIX_W] = rd_q;
  end

  logic [WORD_W-1:0] wgt_mem [WGT_DEPTH];

  // Read-before-write: a same-address read returns the previous contents.
  always_ff @(posedge clk) begin
    if (wgt_we) wgt_mem[wgt_cnt[WA-1:0]] <= writedata;
    wgt_rdata <= wgt_mem[wgt_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      img_cnt   <= '0;
      wgt_cnt   <= '0;
      rd_ptr    <= '0;
      load_cnt  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      readdata  <= '0;
    end else begin
      readdata <= (chipselect && read && (address == 2'd2)) ? status : 32'd0;

      if ((img_we || wgt_we) && (load_cnt != CNT_MAX)) load_cnt <= load_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (data_wr) begin
            img_cnt <= IC'(1);
            state   <= (IMG_DEPTH == 1) ? LOAD_WGT : LOAD_IMG;
          end
        end
        LOAD_IMG: begin
          if (data_wr) begin
            img_cnt <= img_cnt + 1'b1;
            if (img_cnt == IMG_LAST) state <= LOAD_WGT;
          end
        end
        LOAD_WGT: begin
          if (data_wr) begin
            wgt_cnt <= wgt_cnt + 1'b1;
            if (wgt_cnt == WGT_LAST) state <= READY;
          end
        end
        READY: begin
          if (data_wr) overflow <= 1'b1;
          if (start) begin
            state  <= STREAM;
            rd_ptr <= '0;
          end
        end
        STREAM: begin
          if (data_wr) overflow <= 1'b1;
          if (fetch) begin
            out_valid <= 1'b1;
            out_last  <= (rd_ptr == IMG_LAST);
            rd_ptr    <= rd_ptr + 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) state <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_image_loader.sv
// tb/tb_banked_image_loader.sv - randomized self-checking bench for banked_image_loader
module tb_banked_image_loader;

  localparam int IMG = 4;
  localparam int WGT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  wgt_raddr;
  logic [31:0] wgt_rdata;

  banked_image_loader #(
    .PIX_W(8), .NUM_BANKS(4), .IMG_DEPTH(IMG), .WGT_DEPTH(WGT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .wgt_raddr(wgt_raddr), .wgt_rdata(wgt_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: image words, weight words, total loads, sticky overflow.
  logic [31:0] img_m [IMG];
  logic [31:0] wgt_m [WGT];
  int          m_cnt;
  bit          m_ovf;
  bit          m_streaming;
  bit          wgt_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_state();
    if (m_streaming) return 4;
    if (m_cnt == 0) return 0;
    if (m_cnt < IMG) return 1;
    if (m_cnt < IMG + WGT) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_status();
    return {16'(m_cnt), 12'd0, m_ovf, 3'(m_state())};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_read(2'd2, d);
    check(tag, d, m_status());
  endtask

  task automatic model_clear();
    m_cnt = 0; m_ovf = 1'b0; m_streaming = 1'b0;
  endtask

  task automatic do_reset(input bit with_access);
    reset = 1'b1;
    if (with_access) begin
      chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = $urandom;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; chipselect = 1'b0; write = 1'b0;
    model_clear();
  endtask

  // DATA write; while loading weights after a previous load, also probes the
  // same address to confirm the read returns the pre-write contents.
  task automatic load_word(input logic [31:0] d);
    int n;
    bit chk;
    logic [31:0] old;
    n = m_cnt;
    chk = (n >= IMG) && (n < IMG + WGT) && wgt_known;
    old = 32'd0;
    if (chk) begin
      old = wgt_m[n - IMG];
      wgt_raddr = 3'(n - IMG);
    end
    bus_write(2'd0, d);
    if (chk) check("wgt_rd_old", wgt_rdata, old);
    if (n < IMG) begin
      img_m[n] = d; m_cnt++;
    end else if (n < IMG + WGT) begin
      wgt_m[n - IMG] = d; m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic ctrl(input logic [31:0] v);
    bus_write(2'd1, v);
    if (v[1]) model_clear();
    else if (v[0] && m_state() == 3) m_streaming = 1'b1;
  endtask

  task automatic load_random();
    for (int i = 0; i < IMG + WGT; i++) load_word($urandom);
    wgt_known = 1'b1;
  endtask

  task automatic check_weights();
    int a;
    for (int i = 0; i < WGT; i++) begin
      a = $urandom_range(0, WGT - 1);
      wgt_raddr = 3'(a);
      @(posedge clk); #1;
      check("wgt_rdata", wgt_rdata, wgt_m[a]);
    end
  endtask

  // Consumes one streamed image. mode 0: always ready, 1: ready every third
  // cycle, 2: random ready. Call right after the start write returns.
  task automatic run_stream(input int mode, input bit timing);
    int idx;
    bit held_v;
    logic [31:0] held_d;
    idx = 0; held_v = 1'b0; held_d = 32'd0;
    for (int cyc = 0; cyc < 64 && idx < IMG; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (timing && cyc == 0) check("first_valid_lat", {31'd0, out_valid}, 32'd0);
      if (held_v) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, held_d);
      end
      held_v = 1'b0;
      if (out_valid) begin
        if (timing) check("b2b_cycle", 32'(cyc), 32'(idx + 1));
        if (out_ready) begin
          check("out_data", out_data, img_m[idx]);
          check("out_last", {31'd0, out_last}, {31'd0, idx == IMG - 1});
          idx++;
        end else begin
          held_v = 1'b1;
          held_d = out_data;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    m_streaming = 1'b0;
    check("stream_words", 32'(idx), 32'(IMG));
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_extra_word", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit got;
    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 2'd0; writedata = 32'd0; out_ready = 1'b0; wgt_raddr = 3'd0;
    wgt_known = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    chk_status("rst_status");

    // Scenario 1: directed load.
    load_word(32'h03020100);
    load_word(32'h13121110);
    chk_status("status_load_img");
    bus_read(2'd0, d);
    check("read_data_reg", d, 32'd0);
    chipselect = 1'b0; write = 1'b1; address = 2'd0; writedata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    write = 1'b0;
    chk_status("cs0_ignored");
    bus_write(2'd3, 32'h12345678);
    bus_read(2'd3, d);
    check("read_reserved", d, 32'd0);
    load_word(32'h23222120);
    load_word(32'h33323130);
    for (int i = 0; i < WGT; i++) load_word(32'hA0 + i);
    wgt_known = 1'b1;
    bus_read(2'd2, d);
    check("status_loaded", d, 32'h000C0003);
    check("status_model", d, m_status());
    @(posedge clk); #1;
    check("readdata_zero_after", readdata, 32'd0);
    wgt_raddr = 3'd5;
    @(posedge clk); #1;
    check("wgt_addr5", wgt_rdata, 32'h000000A5);
    check_weights();

    // Scenario 2: full-rate stream with exact timing.
    ctrl(32'd1);
    run_stream(0, 1'b1);
    chk_status("status_after_stream");

    // Scenario 3: backpressure.
    ctrl(32'd1);
    run_stream(1, 1'b0);
    ctrl(32'd1);
    run_stream(2, 1'b0);

    // Scenario 4: overflow in READY.
    load_word(32'hDEADBEEF);
    bus_read(2'd2, d);
    check("status_overflow", d, 32'h000C000B);
    ctrl(32'd1);
    run_stream(2, 1'b0);
    chk_status("status_ovf_sticky");

    // Scenario 5: clear while the second word is stalled.
    ctrl(32'd1);
    out_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        check("clr_word0", out_data, img_m[0]);
        got = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    check("clr_first_seen", {31'd0, got}, 32'd1);
    out_ready = 1'b0;
    check("clr_word1_valid", {31'd0, out_valid}, 32'd1);
    check("clr_word1_data", out_data, img_m[1]);
    @(posedge clk); #1;
    check("clr_word1_held", out_data, img_m[1]);
    ctrl(32'd3);
    check("clr_valid_drop", {31'd0, out_valid}, 32'd0);
    bus_read(2'd2, d);
    check("clr_status", d, 32'h00000000);
    load_random();
    chk_status("reload_status");
    ctrl(32'd1);
    run_stream(2, 1'b0);
    check_weights();

    // Scenario 6: reset mid-load with a simultaneous access, then start in IDLE.
    load_word($urandom);
    load_word($urandom);
    chk_status("midload_status");
    do_reset(1'b1);
    bus_read(2'd2, d);
    check("reset_status", d, 32'h00000000);
    ctrl(32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("idle_start_ignored", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk_status("idle_status");

    // Randomized rounds.
    for (int r = 0; r < 3; r++) begin
      load_random();
      chk_status("rnd_ready");
      check_weights();
      ctrl(32'd1);
      run_stream(2, 1'b0);
      ctrl(32'd1);
      run_stream(r % 2, 1'b0);
      ctrl(32'd2);
      chk_status("rnd_clear");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/banked_image_loader.md
Name: banked_image_loader

Overview:
Avalon-MM slave that receives packed pixel words from the HPS and loads the image and weights into on-chip memory. The first IMG_DEPTH data words are split byte-lane-wise across NUM_BANKS image banks. The next WGT_DEPTH words go sequentially into a weight RAM. On command, the image is streamed out to the conv engine as parallel bank reads over a valid/ready interface; weights are served through a random-access read port.

Parameters:
PIX_W, 8, bits per pixel
NUM_BANKS, 4, image banks (pixels per bus word); WORD_W = NUM_BANKS*PIX_W
IMG_DEPTH, 196, words per image bank
WGT_DEPTH, 1024, weight RAM depth in WORD_W words
CNT_W, 16, width of status load counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  2  0=DATA, 1=CTRL, 2=STATUS, 3=reserved (reads 0, writes ignored)
writedata  in  WORD_W  write word; lane k = writedata[k*PIX_W +: PIX_W] goes to bank k
readdata  out  32  registered read data
out_valid  out  1  stream word valid
out_ready  in  1  consumer accepts word
out_data  out  WORD_W  lane k = image bank k
out_last  out  1  marks word at bank address IMG_DEPTH-1
wgt_raddr  in  clog2(WGT_DEPTH)  weight read address
wgt_rdata  out  WORD_W  weight data, 1-cycle latency, valid in every state

Behaviour:
- Reset (synchronous) and CTRL clear: state=IDLE, counters=0, overflow=0, out_valid=0, out_last=0, readdata=0. Memory contents are preserved.
- Accepted access = chipselect & (write|read). A DATA write is a write to address 0.
- States:
  - IDLE: a DATA write stores lane k at bank k, addr 0; img_cnt=1; goes to LOAD_IMG. If IMG_DEPTH==1, goes to LOAD_WGT instead.
  - LOAD_IMG: each DATA write stores at addr img_cnt, then img_cnt++. The write that makes img_cnt==IMG_DEPTH moves to LOAD_WGT.
  - LOAD_WGT: each DATA write stores the full word at wgt_cnt, then wgt_cnt++. Reaching WGT_DEPTH moves to READY.
  - READY: DATA writes are ignored and set overflow (sticky). A CTRL write with bit0=1 moves to STREAM.
  - STREAM: DATA writes are ignored and set overflow. Returns to READY the cycle after the handshake with out_last=1. The image is retained, so restreaming is allowed.
- Stream timing:
  - Start written in cycle T -> first out_valid=1 at T+2.
  - Sustained 1 word/cycle while out_ready=1, using a prefetch/skid register (no bubbles).
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_valid drops the cycle after the last word is accepted.
  - Words are emitted at addr 0..IMG_DEPTH-1 in order, exactly once per start.
- CTRL:
  - bit0=start, bit1=clear.
  - clear takes priority and is honoured in any state, including mid-stream; out_valid drops next cycle.
  - start outside READY is ignored.
- STATUS (readdata valid the cycle after an accepted read; 0 otherwise; read of DATA/CTRL returns 0):
  - [2:0] state: IDLE=0, LOAD_IMG=1, LOAD_WGT=2, READY=3, STREAM=4
  - [3] overflow
  - [15:4] 0
  - [31:16] total accepted load writes (img+wgt), saturating at 2^CNT_W-1 (CNT_W<=16)
- Accepted loads per cycle: at most one. A write with chipselect=0 has no effect.
- Weight RAM write and wgt_raddr to the same address in one cycle: wgt_rdata returns the old data.
- Counters never wrap: img_cnt stops at IMG_DEPTH, wgt_cnt stops at WGT_DEPTH.
- Simultaneous reset with any access: reset wins.

Test Plan:
(All scenarios use PIX_W=8, NUM_BANKS=4, IMG_DEPTH=4, WGT_DEPTH=8.)
1. Load: write DATA 0x03020100, 0x13121110, 0x23222120, 0x33323130, then 8 weight words 0xA0..0xA7 -> STATUS=0x000C0003; wgt_raddr=5 gives wgt_rdata=0xA5 one cycle later.
2. Stream, out_ready=1: CTRL=1 at T -> out_valid at T+2..T+5 with out_data 0x03020100..0x33323130 back-to-back, out_last only at T+5; STATUS state=3 afterwards.
3. Backpressure: out_ready toggles 1,0,0,1,... -> every word appears once in order; out_data is stable during stalls; no extra or dropped words.
4. Overflow: in READY, write DATA 0xDEADBEEF -> STATUS bit3=1, count unchanged at 12, banks unchanged (restream matches scenario 2).
5. Clear mid-stream: CTRL=3 while the 2nd word is stalled -> out_valid=0 next cycle, STATUS=0x00000000; a reload of 12 words reaches READY again.
6. Reset mid-load after 2 DATA writes -> state IDLE, STATUS=0. A start in IDLE is ignored: out_valid stays 0.
